// File: rtl/alu_dispatch_if.sv
// Handshake bundle between the instruction/operand source, alu_dispatch and the downstream ALU stage.
interface alu_dispatch_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        illegal;

    modport slave (
        input  in_valid, instr, rs_val, rt_val, out_ready,
        output in_ready, out_valid, alu_op, alu_a, alu_b, illegal
    );

    modport master (
        output in_valid, instr, rs_val, rt_val, out_ready,
        input  in_ready, out_valid, alu_op, alu_a, alu_b, illegal
    );
endinterface

// File: rtl/alu_dispatch.sv
// Decodes a MIPS instruction into a registered ALU op/operand bundle behind a valid/ready skid-free stage.
// Optional issue/illegal counters are built when ALU_DISPATCH_STATS_EN is defined.
module alu_dispatch (
    input  logic          clk,
    input  logic          rst_n,
    alu_dispatch_if.slave bus
`ifdef ALU_DISPATCH_STATS_EN
    ,
    output logic [15:0]   issue_cnt,
    output logic [7:0]    illegal_cnt
`endif
);
    localparam int unsigned DW    = 32;
    localparam int unsigned OPW   = 3;
    localparam int unsigned IMMW  = 16;
    localparam int unsigned FLDW  = 6;

    localparam logic [FLDW-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [FLDW-1:0] OPC_ADDI  = 6'b001000;
    localparam logic [FLDW-1:0] OPC_SLTI  = 6'b001010;
    localparam logic [FLDW-1:0] OPC_ANDI  = 6'b001100;
    localparam logic [FLDW-1:0] OPC_ORI   = 6'b001101;
    localparam logic [FLDW-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [FLDW-1:0] OPC_LW    = 6'b100011;
    localparam logic [FLDW-1:0] OPC_SW    = 6'b101011;

    localparam logic [FLDW-1:0] FN_ADD = 6'b100000;
    localparam logic [FLDW-1:0] FN_SUB = 6'b100010;
    localparam logic [FLDW-1:0] FN_AND = 6'b100100;
    localparam logic [FLDW-1:0] FN_OR  = 6'b100101;
    localparam logic [FLDW-1:0] FN_SLT = 6'b101010;

    localparam logic [OPW-1:0] ALU_AND = 3'b000;
    localparam logic [OPW-1:0] ALU_OR  = 3'b001;
    localparam logic [OPW-1:0] ALU_ADD = 3'b010;
    localparam logic [OPW-1:0] ALU_SUB = 3'b110;
    localparam logic [OPW-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic           illegal;
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } bundle_t;

    bundle_t         dec_c;
    bundle_t         bundle_q, bundle_d;
    logic            valid_q, valid_d;
    logic            in_xfer_c, out_xfer_c;
    logic            legal_c, use_imm_c, zext_c;
    logic [OPW-1:0]  op_c;
    logic [FLDW-1:0] opcode_c, funct_c;
    logic [IMMW-1:0] imm_c;
    logic            unused_reg_fields;

    assign opcode_c          = bus.instr[31:26];
    assign funct_c           = bus.instr[5:0];
    assign imm_c             = bus.instr[15:0];
    // Register specifiers arrive pre-resolved as rs_val/rt_val.
    assign unused_reg_fields = ^bus.instr[25:16];

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign in_xfer_c    = bus.in_valid && bus.in_ready;
    assign out_xfer_c   = valid_q && bus.out_ready;

    // Instruction decode; anything unrecognised becomes an all-zero illegal bundle.
    always_comb begin
        legal_c   = 1'b1;
        op_c      = ALU_AND;
        use_imm_c = 1'b0;
        zext_c    = 1'b0;
        case (opcode_c)
            OPC_RTYPE: begin
                case (funct_c)
                    FN_ADD:  op_c = ALU_ADD;
                    FN_SUB:  op_c = ALU_SUB;
                    FN_AND:  op_c = ALU_AND;
                    FN_OR:   op_c = ALU_OR;
                    FN_SLT:  op_c = ALU_SLT;
                    default: legal_c = 1'b0;
                endcase
            end
            OPC_ADDI, OPC_LW, OPC_SW: begin
                op_c      = ALU_ADD;
                use_imm_c = 1'b1;
            end
            OPC_SLTI: begin
                op_c      = ALU_SLT;
                use_imm_c = 1'b1;
            end
            OPC_ANDI: begin
                op_c      = ALU_AND;
                use_imm_c = 1'b1;
                zext_c    = 1'b1;
            end
            OPC_ORI: begin
                op_c      = ALU_OR;
                use_imm_c = 1'b1;
                zext_c    = 1'b1;
            end
            OPC_BEQ: op_c = ALU_SUB;
            default: legal_c = 1'b0;
        endcase

        dec_c         = '0;
        dec_c.illegal = 1'b1;
        if (legal_c) begin
            dec_c.illegal = 1'b0;
            dec_c.op      = op_c;
            dec_c.a       = bus.rs_val;
            if (!use_imm_c)
                dec_c.b = bus.rt_val;
            else if (zext_c)
                dec_c.b = DW'(imm_c);
            else
                dec_c.b = {{(DW-IMMW){imm_c[IMMW-1]}}, imm_c};
        end
    end

    // A new input wins over a drain, so simultaneous transfers keep the stage full.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (in_xfer_c) begin
            valid_d  = 1'b1;
            bundle_d = dec_c;
        end else if (out_xfer_c) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.illegal   = bundle_q.illegal;
    assign bus.alu_op    = bundle_q.op;
    assign bus.alu_a     = bundle_q.a;
    assign bus.alu_b     = bundle_q.b;

`ifdef ALU_DISPATCH_STATS_EN
    localparam int unsigned ISSUE_W = 16;
    localparam int unsigned ILL_W   = 8;

    logic [ISSUE_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [ILL_W-1:0]   illegal_cnt_q, illegal_cnt_d;

    // Issue count wraps; illegal count saturates so a storm of bad opcodes stays visible.
    always_comb begin
        issue_cnt_d   = issue_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (out_xfer_c) begin
            issue_cnt_d = issue_cnt_q + ISSUE_W'(1);
            if (bundle_q.illegal && (illegal_cnt_q != {ILL_W{1'b1}}))
                illegal_cnt_d = illegal_cnt_q + ILL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            issue_cnt_q   <= issue_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign issue_cnt   = issue_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: decode table, back-pressure, async reset and (with ALU_DISPATCH_STATS_EN) counters.
module tb_alu_dispatch;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_dispatch_if bus();

`ifdef ALU_DISPATCH_STATS_EN
    logic [15:0] issue_cnt;
    logic [7:0]  illegal_cnt;
`endif

    alu_dispatch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef ALU_DISPATCH_STATS_EN
        ,
        .issue_cnt   (issue_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = v;
        bus.instr    = ins;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Pushes n copies of ins back-to-back, then one idle cycle to drain the last bundle.
    task automatic stream(input logic [31:0] ins, input int n);
        bus.out_ready = 1'b1;
        drive(1'b1, ins, 32'h1, 32'h2);
        repeat (n) step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        //                 instr          rs            rt            op     a             b             ill
        vecs[0]  = '{32'h00430820, 32'h00000005, 32'h00000007, 3'b010, 32'h00000005, 32'h00000007, 1'b0}; // add
        vecs[1]  = '{32'h00430822, 32'h00000010, 32'h00000003, 3'b110, 32'h00000010, 32'h00000003, 1'b0}; // sub
        vecs[2]  = '{32'h00430824, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0}; // and
        vecs[3]  = '{32'h00430825, 32'h12345678, 32'h87654321, 3'b001, 32'h12345678, 32'h87654321, 1'b0}; // or
        vecs[4]  = '{32'h0043082A, 32'h00000001, 32'hFFFFFFFF, 3'b111, 32'h00000001, 32'hFFFFFFFF, 1'b0}; // slt
        vecs[5]  = '{32'h2000FFFE, 32'h00000064, 32'hAAAAAAAA, 3'b010, 32'h00000064, 32'hFFFFFFFE, 1'b0}; // addi
        vecs[6]  = '{32'h3000FFFE, 32'hFFFFFFFF, 32'hAAAAAAAA, 3'b000, 32'hFFFFFFFF, 32'h0000FFFE, 1'b0}; // andi
        vecs[7]  = '{32'h34008001, 32'h00000100, 32'h55555555, 3'b001, 32'h00000100, 32'h00008001, 1'b0}; // ori
        vecs[8]  = '{32'h28008000, 32'h00000009, 32'h55555555, 3'b111, 32'h00000009, 32'hFFFF8000, 1'b0}; // slti
        vecs[9]  = '{32'h8C000004, 32'h10000000, 32'h00000000, 3'b010, 32'h10000000, 32'h00000004, 1'b0}; // lw
        vecs[10] = '{32'hAC00FFFC, 32'h20000000, 32'h00000011, 3'b010, 32'h20000000, 32'hFFFFFFFC, 1'b0}; // sw
        vecs[11] = '{32'h10430003, 32'h0000ABCD, 32'h0000ABCD, 3'b110, 32'h0000ABCD, 32'h0000ABCD, 1'b0}; // beq
        vecs[12] = '{32'hFC000000, 32'h11111111, 32'h22222222, 3'b000, 32'h00000000, 32'h00000000, 1'b1}; // op 111111
        vecs[13] = '{32'h00000008, 32'h33333333, 32'h44444444, 3'b000, 32'h00000000, 32'h00000000, 1'b1}; // jr (bad funct)

        // Reset state, observed before any clock edge.
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_illegal",   32'(bus.illegal),   32'h0);
        chk("rst_alu_op",    32'(bus.alu_op),    32'h0);
        chk("rst_alu_a",     bus.alu_a,          32'h0);
        chk("rst_alu_b",     bus.alu_b,          32'h0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
        step();
        rst_n = 1'b1;
        step();

        // Decode table, streamed back-to-back at full throughput.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'h1);
            step();
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("v%0d_alu_op", i),    32'(bus.alu_op),    32'(vecs[i].op));
            chk($sformatf("v%0d_alu_a", i),     bus.alu_a,          vecs[i].a);
            chk($sformatf("v%0d_alu_b", i),     bus.alu_b,          vecs[i].b);
            chk($sformatf("v%0d_illegal", i),   32'(bus.illegal),   32'(vecs[i].ill));
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk("drain_out_valid", 32'(bus.out_valid), 32'h0);

        // Back-pressure: bundle A held three cycles, then swapped for B in one cycle.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00430820, 32'h0000000A, 32'h0000000B);
        step();
        chk("bp_a_valid", 32'(bus.out_valid), 32'h1);
        drive(1'b1, 32'h00430822, 32'h00000010, 32'h00000020);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_hold%0d_in_ready", c), 32'(bus.in_ready), 32'h0);
            step();
            chk($sformatf("bp_hold%0d_valid", c), 32'(bus.out_valid), 32'h1);
            chk($sformatf("bp_hold%0d_op", c),    32'(bus.alu_op),    32'h2);
            chk($sformatf("bp_hold%0d_a", c),     bus.alu_a,          32'h0000000A);
            chk($sformatf("bp_hold%0d_b", c),     bus.alu_b,          32'h0000000B);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        chk("bp_b_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_b_op",    32'(bus.alu_op),    32'h6);
        chk("bp_b_a",     bus.alu_a,          32'h00000010);
        chk("bp_b_b",     bus.alu_b,          32'h00000020);
        drive(1'b0, 32'hFC000000, 32'hDEADBEEF, 32'hDEADBEEF);
        step();
        chk("bp_b_once", 32'(bus.out_valid), 32'h0);
        step();
        chk("idle_ignored_valid",   32'(bus.out_valid), 32'h0);
        chk("idle_ignored_a",       bus.alu_a,          32'h00000010);
        chk("idle_ignored_illegal", 32'(bus.illegal),   32'h0);

        // Asynchronous reset mid-cycle while a bundle is stalled.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00430820, 32'h00000077, 32'h00000088);
        step();
        chk("ar_loaded", 32'(bus.out_valid), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(bus.out_valid), 32'h0);
        chk("ar_alu_a",     bus.alu_a,          32'h0);
        chk("ar_alu_b",     bus.alu_b,          32'h0);
        chk("ar_alu_op",    32'(bus.alu_op),    32'h0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h00430825, 32'h00000003, 32'h00000005);
        step();
        chk("ar_first_valid", 32'(bus.out_valid), 32'h1);
        chk("ar_first_op",    32'(bus.alu_op),    32'h1);
        chk("ar_first_a",     bus.alu_a,          32'h00000003);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk("ar_first_drained", 32'(bus.out_valid), 32'h0);

`ifdef ALU_DISPATCH_STATS_EN
        do_reset();
        #1;
        chk("st_rst_issue",   32'(issue_cnt),   32'h0);
        chk("st_rst_illegal", 32'(illegal_cnt), 32'h0);
        stream(32'hFC000000, 1);
        chk("st_one_issue",   32'(issue_cnt),   32'h1);
        chk("st_one_illegal", 32'(illegal_cnt), 32'h1);

        do_reset();
        stream(32'h00430820, 65537);
        chk("st_wrap_issue",   32'(issue_cnt),   32'h1);
        chk("st_wrap_illegal", 32'(illegal_cnt), 32'h0);

        do_reset();
        stream(32'hFC000000, 300);
        chk("st_sat_illegal", 32'(illegal_cnt), 32'hFF);
        chk("st_sat_issue",   32'(issue_cnt),   32'd300);
`else
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
